// File: rtl/tt_um_restoring_divider4_pkg.sv
// Shared constants and types for the 4-bit restoring divider:
// FSM states, uio pin positions and the divide-by-zero result code.
package tt_div_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int START_BIT = 0;
    localparam int BUSY_BIT  = 1;
    localparam int DONE_BIT  = 2;
    localparam int DBZ_BIT   = 3;

    localparam logic [7:0]       UIO_OE_VAL   = 8'b0000_1110;
    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF;

endpackage

// File: rtl/tt_um_restoring_divider4_if.sv
// Tiny Tapeout pin bundle for the divider; master drives operands/start,
// slave returns result, status and output enables.
interface tt_div_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_restoring_divider4_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in the quotient bit.
module div_step
    import tt_div_pkg::*;
(
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shift;
    logic           fits;

    // rem stays below B between iterations, so its top bit is always 0 here.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign fits      = (rem_shift >= {1'b0, b});
    assign rem_next  = fits ? (rem_shift - {1'b0, b}) : rem_shift;
    assign quo_next  = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/tt_um_restoring_divider4.sv
// Multi-cycle 4-bit unsigned restoring divider in the Tiny Tapeout wrapper:
// A/B on ui_in, start on uio_in[0], {R,Q} on uo_out, busy/done/dbz on uio_out.
module tt_um_restoring_divider4
    import tt_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    state_t            state, state_next;
    logic [WIDTH:0]    rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  b_reg;
    logic [CNT_W-1:0]  count;
    logic [7:0]        result;
    logic              dbz;

    logic [WIDTH-1:0]  a_in, b_in;
    logic              start, accept, b_zero;
    logic [WIDTH:0]    rem_next;
    logic [WIDTH-1:0]  quo_next;

    logic unused_inputs;
    assign unused_inputs = &{ena, uio_in[7:1], 1'b0};

    assign a_in   = ui_in[WIDTH-1:0];
    assign b_in   = ui_in[2*WIDTH-1:WIDTH];
    assign start  = uio_in[START_BIT];
    assign accept = start && (state != RUN);
    assign b_zero = (b_in == '0);

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .b        (b_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // NOTE: state-holding logic uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default assignment first guarantees state_next is driven on
    // every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (accept) state_next = b_zero ? DONE : RUN;
            RUN:        if (count == LAST_COUNT) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem    <= '0;
            quo    <= '0;
            b_reg  <= '0;
            count  <= '0;
            result <= '0;
            dbz    <= 1'b0;
        end else if (accept) begin
            b_reg <= b_in;
            rem   <= '0;
            quo   <= a_in;
            count <= '0;
            dbz   <= b_zero;
            // Division by zero finishes immediately; otherwise result holds until RUN ends.
            if (b_zero) result <= {a_in, DBZ_QUOTIENT};
        end else if (state == RUN) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LAST_COUNT) result <= {rem_next[WIDTH-1:0], quo_next};
        end
    end

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = (state == RUN);
        uio_out[DONE_BIT] = (state == DONE);
        uio_out[DBZ_BIT]  = dbz;
    end

    assign uo_out = result;
    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_restoring_divider4.sv
// Directed self-checking bench for tt_um_restoring_divider4: reset, latency,
// edge cases, divide-by-zero, ignored restart, mid-op reset, back-to-back, sweep.
module tb_tt_um_restoring_divider4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    tt_div_if pins ();

    tt_um_restoring_divider4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (pins.ui_in),
        .uio_in  (pins.uio_in),
        .uo_out  (pins.uo_out),
        .uio_out (pins.uio_out),
        .uio_oe  (pins.uio_oe)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] ST_IDLE = 8'h00;
    localparam logic [7:0] ST_BUSY = 8'h02;
    localparam logic [7:0] ST_DONE = 8'h04;
    localparam logic [7:0] ST_DBZ  = 8'h0C;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one division, scramble ui_in afterwards, and check 4 busy cycles
    // (result held from before), then done with the expected {R,Q}.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] expected);
        logic [7:0] prev;
        prev = pins.uo_out;
        pins.ui_in     = {b, a};
        pins.uio_in[0] = 1'b1;
        tick();
        pins.uio_in[0] = 1'b0;
        pins.ui_in     = ~{b, a};
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, pins.uio_out, ST_BUSY);
            if (i == 0) check({tag, " held"}, pins.uo_out, prev);
            tick();
        end
        check({tag, " done"}, pins.uio_out, ST_DONE);
        check({tag, " result"}, pins.uo_out, expected);
    endtask

    initial begin
        logic [3:0] q, r;
        logic [7:0] ok;

        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;
        rst_n       = 1'b0;
        tick();
        tick();
        check("reset uo_out", pins.uo_out, 8'h00);
        check("reset uio_out", pins.uio_out, ST_IDLE);
        check("reset uio_oe", pins.uio_oe, 8'h0E);
        rst_n = 1'b1;
        tick();
        check("idle uio_out", pins.uio_out, ST_IDLE);

        run_op("13/3", 4'd13, 4'd3, 8'h14);
        run_op("15/1", 4'd15, 4'd1, 8'h0F);
        run_op("2/7", 4'd2, 4'd7, 8'h20);
        run_op("15/15", 4'd15, 4'd15, 8'h01);

        // Divide by zero: done+dbz one cycle after start, busy never set.
        pins.ui_in     = 8'h09;
        pins.uio_in[0] = 1'b1;
        tick();
        pins.uio_in[0] = 1'b0;
        check("dbz status", pins.uio_out, ST_DBZ);
        check("dbz result", pins.uo_out, 8'h9F);
        tick();
        check("dbz hold status", pins.uio_out, ST_DBZ);
        check("dbz hold result", pins.uo_out, 8'h9F);

        // Restart attempt in the middle of RUN must be ignored.
        pins.ui_in     = 8'h3D;
        pins.uio_in[0] = 1'b1;
        tick();
        pins.uio_in[0] = 1'b0;
        check("ign busy1", pins.uio_out, ST_BUSY);
        check("ign dbz cleared result held", pins.uo_out, 8'h9F);
        tick();
        pins.ui_in     = 8'h21;
        pins.uio_in[0] = 1'b1;
        tick();
        pins.uio_in[0] = 1'b0;
        check("ign busy3", pins.uio_out, ST_BUSY);
        tick();
        check("ign busy4", pins.uio_out, ST_BUSY);
        tick();
        check("ign done", pins.uio_out, ST_DONE);
        check("ign result", pins.uo_out, 8'h14);

        // Reset in the middle of RUN clears everything; then a fresh op works.
        pins.ui_in     = 8'h2F;
        pins.uio_in[0] = 1'b1;
        tick();
        pins.uio_in[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst uo_out", pins.uo_out, 8'h00);
        check("midrst uio_out", pins.uio_out, ST_IDLE);
        rst_n = 1'b1;
        run_op("after rst 14/4", 4'd14, 4'd4, 8'h23);

        // Start held high: DONE relaunches with newly presented operands.
        pins.ui_in     = 8'h59;
        pins.uio_in[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold busy", pins.uio_out, ST_BUSY);
        end
        tick();
        check("hold done", pins.uio_out, ST_DONE);
        check("hold result 9/5", pins.uo_out, 8'h41);
        pins.ui_in = 8'h27;
        tick();
        check("relaunch busy", pins.uio_out, ST_BUSY);
        check("relaunch result held", pins.uo_out, 8'h41);
        pins.uio_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("relaunch busy4", pins.uio_out, ST_BUSY);
        tick();
        check("relaunch done", pins.uio_out, ST_DONE);
        check("relaunch result 7/2", pins.uo_out, 8'h13);

        // All 240 pairs with B != 0, back to back from DONE.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                q = 4'(a / b);
                r = 4'(a % b);
                run_op("sweep", 4'(a), 4'(b), {r, q});
                ok = 8'(((pins.uo_out[3:0] * b + pins.uo_out[7:4]) == a) &&
                        (pins.uo_out[7:4] < b));
                check("sweep invariant", ok, 8'h01);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tt_um_restoring_divider4.md
Name: tt_um_restoring_divider4

Overview:
- Multi-cycle 4-bit unsigned restoring divider in the Tiny Tapeout user-module wrapper.
- Inverse companion to the combinational 4-bit adder: it performs division by repeated shift-and-subtract, using a 5-bit subtractor.
- Operands arrive on ui_in. A start strobe arrives on uio_in[0].
- Quotient and remainder are registered onto uo_out. Status goes out on uio_out.

Parameters:
- WIDTH, 4, operand width. Only 4 is legal with this pinout; it exists for the package constants and the step sub-module.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  [3:0] dividend A; [7:4] divisor B
- uio_in  input  8  [0] start (level-sampled); [7:1] unused
- uo_out  output  8  [3:0] quotient Q; [7:4] remainder R
- uio_out  output  8  [1] busy; [2] done; [3] div_by_zero; [0] and [7:4] are 0
- uio_oe  output  8  constant 8'b0000_1110

Behaviour:
- Reset value of every output (rst_n low at a rising edge):
  - state = IDLE
  - Q, R, busy, done, div_by_zero = 0
  - internal A/B/count registers = 0
  - reset is honoured in any state, including mid-RUN; the partial result is discarded
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from registered state.
- Start acceptance:
  - start is accepted at an edge where start=1 and state is IDLE or DONE.
  - On acceptance, A and B are captured; done and div_by_zero clear.
  - The uo_out result register is not cleared: it holds the previous result until the new one is written.
- Start when B != 0:
  - Next state = RUN.
  - Working registers: rem = 5'b0, quo = A, count = 0.
- Start when B == 0:
  - Next state = DONE directly; no RUN cycles.
  - Q = 4'hF, R = A, div_by_zero = 1. Results are visible one cycle after the start edge.
- RUN, one iteration per edge, MSB first:
  - rem' = {rem[3:0], quo[3]}
  - if rem' >= {1'b0,B}: rem' = rem' - B and the new quo LSB = 1; otherwise the new quo LSB = 0
  - quo shifts left by 1
- RUN completion:
  - After 4 iterations (count == 3 at the edge), state goes to DONE.
  - Q = quo and R = rem[3:0] are written to uo_out on that same edge.
- Latency: start edge N → results and done=1 visible after edge N+4; busy is high during cycles N+1..N+4 (four cycles).
- Start=1 while in RUN is ignored: no restart, no error flag.
- DONE:
  - Holds Q, R and the flags indefinitely.
  - Start in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
  - A continuously high start re-launches every 5 cycles.
- Operand changes on ui_in outside the start edge have no effect.
- Arithmetic width rules: all values unsigned. rem is 5 bits internally, so the compare cannot overflow. The invariant A = Q*B + R with R < B holds for B != 0.
- Unused inputs (ena, uio_in[7:1]) are tied into a dummy wire to suppress lint warnings.

Decomposition:
- Shared package tt_div_pkg:
  - WIDTH
  - state enum {IDLE, RUN, DONE}
  - pin index constants START_BIT=0, BUSY_BIT=1, DONE_BIT=2, DBZ_BIT=3
  - UIO_OE_VAL = 8'b0000_1110
  - DBZ_QUOTIENT = 4'hF
- Sub-module div_step (combinational, one iteration):
  - Inputs: rem[4:0], quo[3:0], B[3:0].
  - Outputs: rem_next, quo_next.
  - Instantiated once; the top level holds the FSM, counter and registers.

Test Plan:
- Reset held 2 cycles → uo_out=0x00, uio_out=0x00, uio_oe=0x0E.
- ui_in=0x3D (A=13, B=3), start pulse 1 cycle:
  - busy=1 for exactly 4 cycles
  - then done=1, uo_out=0x14 (Q=4, R=1)
  - div_by_zero=0
- Edge cases, each checked for latency 4 and the listed result:
  - A=15, B=1 → uo_out=0x0F
  - A=2, B=7 → uo_out=0x20
  - A=15, B=15 → uo_out=0x01
  - exhaustive sweep of all 240 pairs with B != 0, checking A = Q*B + R with R < B
- ui_in=0x09 (B=0), start → one cycle later done=1, div_by_zero=1, uo_out=0x9F. busy never asserts.
- Start A=13, B=3; at cycle 2 of RUN apply ui_in=0x21 with start=1 → ignored; result is still 0x14 at N+4.
- Mid-op reset and back-to-back:
  - reset asserted at cycle 2 of RUN → all outputs 0 next cycle; a new start afterwards gives a correct result
  - start held in DONE → new operands captured, busy=1 on the following cycle
